// File: rtl/ad_parallel_capture_if.sv
// Sample stream from the capture engine to the packet layer.
// Plain valid/ready handshake; data is held stable while valid is high.
interface ad_parallel_capture_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/ad_parallel_capture.sv
// Capture engine for parallel pipelined ADCs: drives the conversion clock,
// samples the bus mid-period, drops pipeline latency and streams results.
module ad_parallel_capture #(
  parameter int DATA_W   = 12,
  parameter int CLK_HALF = 5,
  parameter int PIPE_LAT = 3,
  parameter int AVG_LOG2 = 2,
  parameter int LEN_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [LEN_W-1:0]       burst_len,
  input  logic [DATA_W-1:0]      adc_db,
  output logic                   adc_clk,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  ad_parallel_capture_if.master  stream
);
  localparam int CNT_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int FL_W  = $clog2(PIPE_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  div_cnt_reg;
  logic              adc_clk_reg;
  logic              strobe_reg;
  logic [DATA_W-1:0] db_reg;
  logic [1:0]        mode_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  res_cnt_reg;
  logic [FL_W-1:0]   flush_cnt_reg;
  logic [4:0]        avg_cnt_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              done_reg;
  logic              overflow_reg;

  logic              div_wrap;
  logic [ACC_W-1:0]  acc_sum;
  logic              result_fire;
  logic [DATA_W-1:0] result_val;
  logic              last_result;

  assign div_wrap = (div_cnt_reg == CNT_W'(CLK_HALF - 1));

  // The strobe follows the falling adc_clk edge, when the bus is mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      adc_clk_reg <= 1'b0;
      strobe_reg  <= 1'b0;
      db_reg      <= '0;
    end else begin
      strobe_reg <= 1'b0;
      if (div_wrap) begin
        div_cnt_reg <= '0;
        adc_clk_reg <= ~adc_clk_reg;
        if (adc_clk_reg) begin
          strobe_reg <= 1'b1;
          db_reg     <= adc_db;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    acc_sum     = acc_reg + ACC_W'(db_reg);
    result_fire = 1'b0;
    result_val  = db_reg;
    if (state_reg == RUN && strobe_reg && !stop) begin
      if (mode_reg[1]) begin
        if (avg_cnt_reg == 5'(AVG_N - 1)) begin
          result_fire = 1'b1;
          result_val  = acc_sum[ACC_W-1:AVG_LOG2];
        end
      end else begin
        result_fire = 1'b1;
      end
    end
    last_result = result_fire && mode_reg[0] && (res_cnt_reg == len_reg - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= '0;
      len_reg       <= '0;
      res_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      avg_cnt_reg   <= '0;
      acc_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg      <= mode;
            len_reg       <= (burst_len == '0) ? LEN_W'(1) : burst_len;
            res_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
            avg_cnt_reg   <= '0;
            acc_reg       <= '0;
            state_reg     <= (PIPE_LAT == 0) ? RUN : FLUSH;
          end
        end
        FLUSH: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (strobe_reg) begin
            flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
            if (flush_cnt_reg == FL_W'(PIPE_LAT - 1)) state_reg <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (strobe_reg) begin
            if (mode_reg[1]) begin
              if (avg_cnt_reg == 5'(AVG_N - 1)) begin
                avg_cnt_reg <= '0;
                acc_reg     <= '0;
              end else begin
                avg_cnt_reg <= avg_cnt_reg + 5'd1;
                acc_reg     <= acc_sum;
              end
            end
            if (result_fire) res_cnt_reg <= res_cnt_reg + LEN_W'(1);
            if (last_result) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A result landing on an accepting cycle replaces the old one without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) overflow_reg <= 1'b0;
      if (result_fire) begin
        if (!valid_reg || stream.sample_ready) begin
          data_reg  <= result_val;
          valid_reg <= 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (valid_reg && stream.sample_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign adc_clk             = adc_clk_reg;
  assign busy                = (state_reg != IDLE);
  assign done                = done_reg;
  assign overflow            = overflow_reg;
  assign stream.sample_data  = data_reg;
  assign stream.sample_valid = valid_reg;
endmodule

// File: doc/ad_parallel_capture.md
Name: ad_parallel_capture

Overview:
- Parametrised capture engine for parallel-output pipelined ADCs (AD9220 class).
- Generates the ADC conversion clock from the system clock and samples the parallel data bus at a fixed point in each conversion period.
- Discards the ADC pipeline latency, then delivers samples over a valid/ready stream to the UART/packet layer.
- Modes: continuous or fixed-length burst, each optionally with power-of-two averaging.

Parameters:
- DATA_W, 12: ADC data bus width.
- CLK_HALF, 5: adc_clk half-period in clk cycles (≥1). adc_clk = clk/(2*CLK_HALF), so 50 MHz → 5 MHz at the default.
- PIPE_LAT, 3: number of ADC clocks of pipeline latency; that many samples are discarded after each start.
- AVG_LOG2, 2: averaging window is 2^AVG_LOG2 samples (0..4).
- LEN_W, 16: burst length counter width.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous reset, active-high.
- start  in  1: one-cycle pulse; latches mode and burst_len and begins a capture.
- stop  in  1: one-cycle pulse; aborts the capture.
- mode  in  2: bit0 = burst (0 = continuous); bit1 = averaging enable.
- burst_len  in  LEN_W: number of output samples in burst mode.
- adc_db  in  DATA_W: ADC parallel data bus.
- adc_clk  out  1: ADC conversion clock.
- sample_data  out  DATA_W: output sample.
- sample_valid  out  1: stream valid.
- sample_ready  in  1: stream ready.
- busy  out  1: high in the FLUSH and RUN states.
- done  out  1: one-cycle pulse at burst completion.
- overflow  out  1: sticky flag; set when a result is dropped.

Behaviour:
- Reset values: adc_clk=0, sample_data=0, sample_valid=0, busy=0, done=0, overflow=0. State=IDLE, all counters 0.
- Clock generator:
  - Counter runs 0..CLK_HALF-1; adc_clk toggles on wrap.
  - Runs free in every state except reset, so the ADC stays clocked.
- Sample strobe: asserted for one clk on the cycle adc_clk goes 1→0. adc_db is registered on that cycle (mid-period, data stable).
- FSM states: IDLE, FLUSH, RUN.
  - IDLE → FLUSH on start. Latches mode and burst_len; burst_len=0 is treated as 1. Clears overflow, accumulator and counters.
  - FLUSH: counts PIPE_LAT strobes and discards them, then → RUN. PIPE_LAT=0 goes directly to RUN.
  - RUN, no averaging: each strobe produces a result equal to the registered adc_db.
  - RUN, averaging: strobes are summed into a DATA_W+AVG_LOG2 bit accumulator. After 2^AVG_LOG2 strobes the result is sum>>AVG_LOG2 (truncating) and the accumulator restarts from the next sample.
  - RUN → IDLE in burst mode when the burst_len-th result is produced; done pulses on that same cycle.
  - RUN or FLUSH → IDLE on stop. A partial average is discarded and done is not pulsed.
- Output stream:
  - A result loads sample_data and sets sample_valid one clk after its strobe.
  - sample_valid holds, with sample_data stable, until the cycle sample_valid&&sample_ready. It then clears, unless a new result loads on that same cycle, in which case the new result is accepted (no bubble, no overflow).
  - A result arriving while sample_valid=1 and sample_ready=0 is dropped and sets overflow. The dropped result still counts toward burst_len.
  - A pending sample survives stop and the burst end; it stays valid until consumed.
- Simultaneous events:
  - start while busy is ignored.
  - start and stop in the same cycle in IDLE: start wins.
  - stop in IDLE: no effect.
  - rst at any time: immediate return to reset values, and any pending sample is lost.
- Widths: the accumulator never overflows (DATA_W+AVG_LOG2 bits). The burst counter compares an LEN_W-bit count against the latched length.

Test Plan:
- Reset, then idle 40 clks → adc_clk period 10 clks (5 high, 5 low); busy=0; sample_valid=0 throughout.
- Continuous, no averaging, sample_ready=1, adc_db ramping +1 each strobe starting at 0x100 → first 3 strobes discarded; sample_valid occurs 1 clk after each subsequent strobe; data 0x103, 0x104, ...; overflow=0.
- Burst, burst_len=4, averaging with AVG_LOG2=2, adc_db constant 0x7FF then 0x001 alternating every strobe → 4 outputs each 0x400 (0x1000>>2); done pulses once; busy drops on the same cycle; then IDLE.
- Burst, burst_len=5, sample_ready=0 held → first sample held stable; the following 4 results are dropped; overflow=1 after the 2nd result; done still pulses; overflow cleared by the next start.
- stop asserted 2 strobes into RUN during averaging → no sample_valid for the partial window; busy=0 next clk; a pending earlier sample is still delivered when sample_ready rises.
- rst asserted mid-FLUSH and start pulsed in the same cycle as rst → all outputs at reset values next clk; start is ignored; adc_clk restarts from 0.
